param_register_file: RTL
========================

Name: param_register_file

Overview:
- Parametrised successor of the CPU datapath's 4+4 register file.
- Holds N_GP general-purpose and N_SCR scratch registers, each WIDTH bits.
- Every enabled register executes a shared per-cycle function: load, half-word load, increment, decrement or clear.
- Two independent combinational read ports.
- New in this generation: synchronous reset and a sequenced bulk-clear engine with a Busy/ClearDone handshake. The ALU system uses the bulk-clear engine on context switch.

Parameters:
- WIDTH, 16, register width in bits; must be even and ≥ 4.
- N_GP, 4, number of general-purpose registers; range 1..8.
- N_SCR, 4, number of scratch registers; range 1..8.
- SELW, $clog2(N_GP+N_SCR), read-select width; derived, never overridden.

Ports:
- Clock, input, 1, system clock; all state updates on the rising edge.
- Reset, input, 1, synchronous active-high reset.
- I, input, WIDTH, write data.
- FunSel, input, 3, function applied to every enabled register.
- RegSel, input, N_GP, active-low GP enables; RegSel[N_GP-1-k] enables GP register k.
- ScrSel, input, N_SCR, active-low scratch enables; ScrSel[N_SCR-1-k] enables scratch register k.
- OutASel, input, SELW, read address A; 0..N_GP-1 = GP, N_GP..N_GP+N_SCR-1 = scratch.
- OutBSel, input, SELW, read address B; same map as OutASel.
- ClearReq, input, 1, single-cycle request to start a bulk clear.
- OutA, output, WIDTH, read data A.
- OutB, output, WIDTH, read data B.
- Busy, output, 1, high while bulk clear is in progress.
- ClearDone, output, 1, one-cycle pulse when bulk clear completes.

Behaviour:
- Reset: all registers 0, FSM IDLE, clear index 0, Busy 0, ClearDone 0. Reset overrides every other input, including mid-clear.
- FunSel codes per enabled register, updated on the next edge (L = WIDTH/2, "hi" = upper L bits):
  - 000: decrement.
  - 001: increment.
  - 010: load I.
  - 011: clear.
  - 100: load I[L-1:0] into the low half; hi cleared.
  - 101: load I[L-1:0] into the low half; hi kept.
  - 110: load I[L-1:0] into hi; low half kept.
  - 111: load I[L-1:0] into the low half; hi = sign-extension.
- Increment and decrement wrap modulo 2^WIDTH; no flags are produced.
- Disabled registers hold their value.
- Multiple registers may be enabled in the same cycle; each applies the same FunSel to its own value.
- Reads: OutA/OutB are combinational from the current register contents, with no write-through. An out-of-range select returns 0. Both ports may select the same register.
- FSM states:
  - IDLE: on ClearReq=1, go to CLEAR with idx=0 and Busy=1.
  - CLEAR: each cycle, register idx (flat map) is zeroed and idx increments. When idx = N_GP+N_SCR-1, the FSM goes to DONE.
  - DONE: ClearDone=1 and Busy=0 for one cycle, then return to IDLE.
- Bulk-clear latency: N_GP+N_SCR cycles of Busy, then one ClearDone cycle.
- While Busy=1, all RegSel/ScrSel writes are ignored; reads remain valid and show partially cleared contents.
- ClearReq is ignored while Busy=1 and in DONE; it is accepted again from IDLE.
- ClearReq and a write in the same IDLE cycle: the write is performed on that edge, then the clear sequence starts on the following cycle.

Optional Feature:
- Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: if a read select targets a register that is enabled this cycle with FunSel=010, that port outputs I combinationally instead of the stored value. Other FunSel codes are not bypassed, and bypass is suppressed while Busy=1.
- Undefined: read ports always show stored contents, as specified above.

Decomposition:
- Shared package regfile_pkg holds:
  - The FunSel enum: FS_DEC, FS_INC, FS_LOAD, FS_CLR, FS_LOLO_CLRHI, FS_LOLO_KEEPHI, FS_HI_KEEPLO, FS_LOLO_SEXT.
  - The FSM state enum: ST_IDLE, ST_CLEAR, ST_DONE.
- One natural sub-module, param_register: a WIDTH-bit register with sync reset, an active-high enable, an active-high clr override and the FunSel datapath. It is instantiated N_GP+N_SCR times with a generate loop.
- Read muxes and the FSM live in the top level.

Test Plan (defaults W=16, N_GP=4, N_SCR=4):
- Reset → OutA=OutB=0 for every select; Busy=0, ClearDone=0.
- I=0x1234, FunSel=010, RegSel=4'b0111 → GP0=0x1234. Then FunSel=001 for 2 cycles → OutASel=0 reads 0x1236. Then FunSel=000 on GP0=0x0000 → 0xFFFF.
- Half loads on GP1 (RegSel=4'b1011):
  - GP1=0xABCD, I=0x0080, FunSel=111 → 0xFF80.
  - Then FunSel=110 with I=0x0012 → 0x1280.
  - Then FunSel=100 with I=0x0034 → 0x0034.
- Load all 8 registers with 0xFFFF, pulse ClearReq → Busy high for exactly 8 cycles. A write attempted mid-clear is ignored. ClearDone pulses 1 cycle. All registers read 0.
- Reset asserted on clear cycle 3 → next cycle Busy=0, all registers 0, FSM IDLE; a new ClearReq is accepted.
- With REGFILE_WRITE_BYPASS_EN defined: OutBSel=5, ScrSel=4'b1011, FunSel=010, I=0x5A5A → OutB=0x5A5A in the same cycle. Without the macro, OutB shows the old value until the next edge.

Source files
------------

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared FunSel and bulk-clear FSM encodings for param_register_file
package regfile_pkg;

  // Per-register function applied on the next edge to every enabled register
  typedef enum logic [2:0] {
    FS_DEC         = 3'b000,
    FS_INC         = 3'b001,
    FS_LOAD        = 3'b010,
    FS_CLR         = 3'b011,
    FS_LOLO_CLRHI  = 3'b100,
    FS_LOLO_KEEPHI = 3'b101,
    FS_HI_KEEPLO   = 3'b110,
    FS_LOLO_SEXT   = 3'b111
  } fun_sel_e;

  // Bulk-clear sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_CLEAR = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/param_register.sv
// rtl/param_register.sv - one WIDTH-bit register with sync reset, clear override and FunSel datapath
module param_register
  import regfile_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic             i_clr,
  input  fun_sel_e         i_fun_sel,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_q
);

  localparam int L = WIDTH / 2;

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  // Next value for this register under the shared function code
  always_comb begin
    w_next = r_q;
    case (i_fun_sel)
      FS_DEC:         w_next = r_q - WIDTH'(1);
      FS_INC:         w_next = r_q + WIDTH'(1);
      FS_LOAD:        w_next = i_data;
      FS_CLR:         w_next = '0;
      FS_LOLO_CLRHI:  w_next = {{(WIDTH-L){1'b0}}, i_data[L-1:0]};
      FS_LOLO_KEEPHI: w_next = {r_q[WIDTH-1:L], i_data[L-1:0]};
      FS_HI_KEEPLO:   w_next = {i_data[L-1:0], r_q[L-1:0]};
      FS_LOLO_SEXT:   w_next = {{(WIDTH-L){i_data[L-1]}}, i_data[L-1:0]};
      default:        w_next = r_q;
    endcase
  end

  // Storage: reset first, then the bulk-clear override, then the enabled function
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q <= '0;
    end else if (i_clr) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= w_next;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/param_register_file.sv
// rtl/param_register_file.sv - GP+scratch register file with bulk-clear engine; optional REGFILE_WRITE_BYPASS_EN
module param_register_file
  import regfile_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int N_GP  = 4,
  parameter  int N_SCR = 4,
  localparam int N_REG = N_GP + N_SCR,
  localparam int SELW  = (N_REG > 1) ? $clog2(N_REG) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [2:0]       FunSel,
  input  logic [N_GP-1:0]  RegSel,
  input  logic [N_SCR-1:0] ScrSel,
  input  logic [SELW-1:0]  OutASel,
  input  logic [SELW-1:0]  OutBSel,
  input  logic             ClearReq,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             Busy,
  output logic             ClearDone
);

  state_e           r_state;
  logic [SELW-1:0]  r_idx;
  logic             w_busy;
  fun_sel_e         w_fun;
  logic [N_REG-1:0] w_sel;
  logic [WIDTH-1:0] w_q [N_REG];

  assign w_fun  = fun_sel_e'(FunSel);
  assign w_busy = (r_state == ST_CLEAR);

  // Active-low select buses flattened to active-high enables, GP first then scratch
  always_comb begin
    w_sel = '0;
    for (int k = 0; k < N_GP; k++) begin
      w_sel[k] = ~RegSel[N_GP-1-k];
    end
    for (int k = 0; k < N_SCR; k++) begin
      w_sel[N_GP+k] = ~ScrSel[N_SCR-1-k];
    end
  end

  for (genvar k = 0; k < N_REG; k++) begin : g_reg
    param_register #(.WIDTH(WIDTH)) u_reg (
      .i_clk     (Clock),
      .i_reset   (Reset),
      .i_en      (w_sel[k] & ~w_busy),
      .i_clr     (w_busy && (r_idx == SELW'(k))),
      .i_fun_sel (w_fun),
      .i_data    (I),
      .o_q       (w_q[k])
    );
  end

  // Bulk-clear sequencer: one register zeroed per cycle, then a single done cycle
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (ClearReq) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_idx == SELW'(N_REG - 1)) begin
            r_state <= ST_DONE;
            r_idx   <= '0;
          end else begin
            r_idx <= r_idx + SELW'(1);
          end
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy      = w_busy;
  assign ClearDone = (r_state == ST_DONE);

  // Read ports: stored contents, zero for out-of-range selects, optional load bypass
  always_comb begin
    OutA = '0;
    OutB = '0;
    if (int'(OutASel) < N_REG) OutA = w_q[OutASel];
    if (int'(OutBSel) < N_REG) OutB = w_q[OutBSel];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (!w_busy && (w_fun == FS_LOAD) && (int'(OutASel) < N_REG) && w_sel[OutASel]) OutA = I;
    if (!w_busy && (w_fun == FS_LOAD) && (int'(OutBSel) < N_REG) && w_sel[OutBSel]) OutB = I;
`endif
  end

endmodule
